i2c_master_tx: RTL and testbench

I2C write-only master that produces START, 7-bit address + W, up to five data bytes and STOP on an open-drain SCL/SDA pair. It is the initiator for the camera-side I2C slave, which stores the bytes into its five control registers. Controller logic loads a frame on the parallel inputs, pulses `start`, and gets `done` and `nack` back. Read transfers, clock stretching, repeated START and multi-master arbitration are out of scope.

---
 rtl/i2c_master_tx.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_master_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_tx.sv
// ============================================================================
// Module   : i2c_master_tx
// Function : Write-only I2C master: START, address+W, up to five bytes, STOP.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_master_tx #(
    parameter int         CLK_DIV  = 250,
    parameter logic [6:0] SLV_ADDR = 7'h55
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] tx_len,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    input  logic [7:0] tx_data2,
    input  logic [7:0] tx_data3,
    input  logic [7:0] tx_data4,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       SCL,
    inout  wire        SDA
);

    localparam int                 c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_DATA     = 3'd4,
        S_DATA_ACK = 3'd5,
        S_STOP     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_q;
    logic [2:0]         r_bit;
    logic [2:0]         r_byte;
    logic [2:0]         r_len;
    logic [7:0]         r_data [0:4];
    logic [7:0]         r_shift;
    logic               r_busy;
    logic               r_done;
    logic               r_nack;
    logic               r_scl;
    logic               r_sda_oe;
    logic               r_sda_s1;
    logic               r_sda_s2;

    logic               w_qend;
    logic [2:0]         w_len;
    logic [2:0]         w_byte_nxt;

    assign w_qend     = (r_div == c_DIV_MAX);
    assign w_len      = (tx_len > 3'd5) ? 3'd5 : tx_len;
    assign w_byte_nxt = r_byte + 3'd1;

    assign busy = r_busy;
    assign done = r_done;
    assign nack = r_nack;
    assign SCL  = r_scl;
    assign SDA  = r_sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_sda_s1 <= SDA;
            r_sda_s2 <= r_sda_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_q      <= 2'd0;
            r_bit    <= 3'd0;
            r_byte   <= 3'd0;
            r_len    <= 3'd0;
            r_shift  <= 8'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_nack   <= 1'b0;
            r_scl    <= 1'b1;
            r_sda_oe <= 1'b0;
            for (int i = 0; i < 5; i++) r_data[i] <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_START;
                        r_busy    <= 1'b1;
                        r_nack    <= 1'b0;
                        r_len     <= w_len;
                        r_data[0] <= tx_data0;
                        r_data[1] <= tx_data1;
                        r_data[2] <= tx_data2;
                        r_data[3] <= tx_data3;
                        r_data[4] <= tx_data4;
                        r_shift   <= {SLV_ADDR, 1'b0};
                        r_div     <= '0;
                        r_q       <= 2'd0;
                        r_bit     <= 3'd0;
                        r_byte    <= 3'd0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    if (!w_qend) begin
                        r_div <= r_div + c_DIV_ONE;
                    end else begin
                        r_div <= '0;
                        r_q   <= r_q + 2'd1;
                        case (r_q)
                            2'd0: begin
                                if (r_state == S_STOP) r_scl <= 1'b1;
                            end
                            2'd1: begin
                                // START pulls SDA under a high SCL; STOP releases it
                                if (r_state == S_START)     r_sda_oe <= 1'b1;
                                else if (r_state == S_STOP) r_sda_oe <= 1'b0;
                                else                        r_scl    <= 1'b1;
                            end
                            2'd2: begin
                                if ((r_state == S_ADDR_ACK || r_state == S_DATA_ACK) && r_sda_s2)
                                    r_nack <= 1'b1;
                            end
                            default: begin
                                r_scl <= 1'b0;
                                case (r_state)
                                    S_START: begin
                                        r_state  <= S_ADDR;
                                        r_bit    <= 3'd0;
                                        r_sda_oe <= ~r_shift[7];
                                    end
                                    S_ADDR, S_DATA: begin
                                        if (r_bit == 3'd7) begin
                                            r_state  <= (r_state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                                            r_sda_oe <= 1'b0;
                                        end else begin
                                            r_bit    <= r_bit + 3'd1;
                                            r_shift  <= {r_shift[6:0], 1'b0};
                                            r_sda_oe <= ~r_shift[6];
                                        end
                                    end
                                    S_ADDR_ACK: begin
                                        if (r_nack || r_len == 3'd0) begin
                                            r_state  <= S_STOP;
                                            r_sda_oe <= 1'b1;
                                        end else begin
                                            r_state  <= S_DATA;
                                            r_bit    <= 3'd0;
                                            r_shift  <= r_data[0];
                                            r_sda_oe <= ~r_data[0][7];
                                        end
                                    end
                                    S_DATA_ACK: begin
                                        r_byte <= w_byte_nxt;
                                        if (r_nack || w_byte_nxt >= r_len) begin
                                            r_state  <= S_STOP;
                                            r_sda_oe <= 1'b1;
                                        end else begin
                                            r_state  <= S_DATA;
                                            r_bit    <= 3'd0;
                                            r_shift  <= r_data[w_byte_nxt];
                                            r_sda_oe <= ~r_data[w_byte_nxt][7];
                                        end
                                    end
                                    default: begin
                                        // end of STOP: bus stays idle-high
                                        r_state  <= S_DONE;
                                        r_scl    <= 1'b1;
                                        r_sda_oe <= 1'b0;
                                        r_done   <= 1'b1;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_tx.sv
// ============================================================================
// Module   : tb_i2c_master_tx
// Function : Bench for i2c_master_tx with a behavioural ACKing slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_master_tx;

    localparam int DIV     = 4;
    localparam int BIT_CYC = 4 * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] tx_len;
    logic [7:0] tx_data0, tx_data1, tx_data2, tx_data3, tx_data4;
    logic       busy, done, nack, scl;
    logic       slave_low;
    wire        sda;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_master_tx #(.CLK_DIV(DIV), .SLV_ADDR(7'h55)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_len(tx_len),
        .tx_data0(tx_data0), .tx_data1(tx_data1), .tx_data2(tx_data2),
        .tx_data3(tx_data3), .tx_data4(tx_data4),
        .busy(busy), .done(done), .nack(nack), .SCL(scl), .SDA(sda)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    bit         got_bits [$];
    bit         exp_bits [$];
    int         start_seen = 0;
    int         stop_seen  = 0;
    logic [5:0] ack_mask   = 6'd0;

    typedef struct packed {
        logic [2:0]  len;
        logic [39:0] data;
        logic [5:0]  mask;
        logic        nack;
        logic [2:0]  sent;
        logic [1:0]  mode;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Slave: records SDA at each SCL rise, ACKs slot k when ack_mask[k] is set
    initial begin
        bit ps = 1'b1, pd = 1'b1, cs, cd, in_frame = 1'b0;
        int falls = 0, pull = 0;
        slave_low = 1'b0;
        forever begin
            @(negedge clk);
            cs = scl;
            cd = sda;
            if (reset) begin
                in_frame  = 1'b0;
                slave_low = 1'b0;
                pull      = 0;
            end else begin
                if (ps && cs && pd && !cd && !in_frame) begin
                    in_frame = 1'b1;
                    falls    = 0;
                    start_seen++;
                end else if (ps && cs && !pd && cd && in_frame) begin
                    in_frame = 1'b0;
                    stop_seen++;
                end
                if (in_frame && !ps && cs) got_bits.push_back(cd);
                if (in_frame && ps && !cs) begin
                    slave_low = 1'b0;
                    pull      = 0;
                    if (falls % 9 == 8 && falls / 9 < 6 && ack_mask[falls / 9]) pull = 2;
                    falls++;
                end else if (pull > 0) begin
                    pull--;
                    if (pull == 0) slave_low = 1'b1;
                end
            end
            ps = cs;
            pd = cd;
        end
    end

    // Expected bus bits of one frame, built from the protocol rules
    task automatic model(input logic [2:0] len, input logic [39:0] data, input logic [5:0] mask,
                         output logic m_nack, output int m_sent);
        logic [7:0] ab;
        logic [7:0] b;
        int         n;
        exp_bits.delete();
        ab     = {7'h55, 1'b0};
        n      = (len > 3'd5) ? 5 : int'(len);
        m_sent = 0;
        for (int k = 7; k >= 0; k--) exp_bits.push_back(ab[k]);
        exp_bits.push_back(!mask[0]);
        m_nack = !mask[0];
        for (int i = 0; i < n && !m_nack; i++) begin
            b = data[8*i +: 8];
            for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
            exp_bits.push_back(!mask[i+1]);
            m_sent = i + 1;
            if (!mask[i+1]) m_nack = 1'b1;
        end
        exp_bits.push_back(1'b0);
    endtask

    // mode: 0 plain, 1 restart+data change mid-frame, 2 start in DONE cycle, 3 start right after DONE
    task automatic run_frame(input string tag, input logic [2:0] len, input logic [39:0] data,
                             input logic [5:0] mask, input logic exp_nack, input int exp_sent,
                             input int mode);
        logic m_nack;
        int   m_sent, cyc, s0, p0, mm, bz;
        model(len, data, mask, m_nack, m_sent);
        tx_len   = len;
        tx_data0 = data[7:0];
        tx_data1 = data[15:8];
        tx_data2 = data[23:16];
        tx_data3 = data[31:24];
        tx_data4 = data[39:32];
        ack_mask = mask;
        got_bits.delete();
        s0 = start_seen;
        p0 = stop_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_rise"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (mode == 1 && cyc == 40) begin
                start    = 1'b1;
                tx_data0 = ~tx_data0;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, " frame_cycles"}, cyc, (11 + 9 * exp_sent) * BIT_CYC);
        chk({tag, " nack"}, nack, exp_nack);
        chk({tag, " busy_in_done"}, busy, 1);
        chk({tag, " start_cond"}, start_seen - s0, 1);
        chk({tag, " stop_cond"}, stop_seen - p0, 1);
        chk({tag, " bit_count"}, got_bits.size(), exp_bits.size());
        mm = 0;
        for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
            if (got_bits[i] != exp_bits[i]) mm++;
        chk({tag, " bit_errors"}, mm, 0);
        if (mode == 2) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done_width"}, done, 0);
        if (mode == 3) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({tag, " accept_after_done"}, busy, 1);
            cyc = 0;
            while (!done && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            chk({tag, " second_frame_done"}, done, 1);
            @(negedge clk);
        end else begin
            chk({tag, " busy_after_done"}, busy, 0);
        end
        if (mode == 1 || mode == 2) begin
            bz = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (busy) bz++;
            end
            chk({tag, " no_second_frame"}, bz, 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [7];
        logic       m_nack;
        int         m_sent, k;
        logic [5:0] rm;
        logic [2:0] rl;
        logic [39:0] rd;

        tbl[0] = '{3'd1, 40'h00_00_00_00_A5, 6'h3F, 1'b0, 3'd1, 2'd0};
        tbl[1] = '{3'd5, 40'h05_04_03_02_01, 6'h3F, 1'b0, 3'd5, 2'd2};
        tbl[2] = '{3'd2, 40'h00_00_00_22_11, 6'h3E, 1'b1, 3'd0, 2'd0};
        tbl[3] = '{3'd3, 40'h00_00_30_20_10, 6'h3B, 1'b1, 3'd2, 2'd0};
        tbl[4] = '{3'd1, 40'h00_00_00_00_3C, 6'h3F, 1'b0, 3'd1, 2'd1};
        tbl[5] = '{3'd0, 40'h00_00_00_00_77, 6'h3F, 1'b0, 3'd0, 2'd3};
        tbl[6] = '{3'd7, 40'hE5_D4_C3_B2_A1, 6'h3F, 1'b0, 3'd5, 2'd0};

        reset    = 1'b1;
        start    = 1'b0;
        tx_len   = 3'd0;
        tx_data0 = 8'd0; tx_data1 = 8'd0; tx_data2 = 8'd0; tx_data3 = 8'd0; tx_data4 = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset scl", scl, 1);
        chk("reset sda", sda, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset nack", nack, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_frame($sformatf("vec%0d", i), tbl[i].len, tbl[i].data, tbl[i].mask,
                      tbl[i].nack, int'(tbl[i].sent), int'(tbl[i].mode));

        // Reset while a data byte is on the bus
        tx_len   = 3'd2;
        tx_data0 = 8'h00;
        tx_data1 = 8'h00;
        ack_mask = 6'h3F;
        got_bits.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (got_bits.size() < 12 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("midreset reached_data", (got_bits.size() >= 12) ? 1 : 0, 1);
        chk("midreset sda_low_before", sda, 0);
        #2 reset = 1'b1;
        #1;
        chk("midreset scl", scl, 1);
        chk("midreset sda", sda, 1);
        chk("midreset busy", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset stays_idle", busy, 0);

        for (int i = 0; i < 16; i++) begin
            rl = 3'($urandom_range(0, 7));
            rd = {$urandom(), 8'($urandom())};
            for (int b = 0; b < 6; b++) rm[b] = ($urandom_range(0, 7) != 0);
            model(rl, rd, rm, m_nack, m_sent);
            run_frame($sformatf("rnd%0d", i), rl, rd, rm, m_nack, m_sent, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
